// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - issue, ALU drive and write-back signals of the ALU op sequencer
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_cond;
  logic [3:0]       in_opcode;
  logic             in_s;
  logic [WIDTH-1:0] in_op_a;
  logic [WIDTH-1:0] in_op_b;
  logic [TAG_W-1:0] in_rd;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_rd;
  logic             out_wr;
  logic             out_err;
  logic [3:0]       flags_q;

  modport slave (
    input  in_valid, in_cond, in_opcode, in_s, in_op_a, in_op_b, in_rd,
    output in_ready,
    output alu_a, alu_b, alu_control,
    input  alu_result, alu_flags,
    output out_valid, out_result, out_rd, out_wr, out_err, flags_q,
    input  out_ready
  );

  modport master (
    output in_valid, in_cond, in_opcode, in_s, in_op_a, in_op_b, in_rd,
    input  in_ready,
    input  alu_a, alu_b, alu_control,
    output alu_result, alu_flags,
    input  out_valid, out_result, out_rd, out_wr, out_err, flags_q,
    output out_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - condition-checked one/two-pass ALU issue with NZCV ownership
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011, ALU_XOR = 3'b110, ALU_NOT = 3'b111;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

  state_t state, state_nx;

  logic [3:0]       opcode_q;
  logic             s_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_ctl_q;
  logic [WIDTH-1:0] result_q;
  logic [TAG_W-1:0] rd_q;
  logic             wr_q, err_q;
  logic [3:0]       flags_r;

  logic [WIDTH-1:0] p1_a, p1_b;
  logic [2:0]       p1_ctl;
  logic             accept, go, test_only, arith, last_pass;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cf;
      4'h3:    return !cf;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cf && !z;
      4'h9:    return !cf || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic supported(input logic [3:0] op);
    return !(op inside {4'h5, 4'h6, 4'h7, 4'hB});
  endfunction

  assign accept    = (state == IDLE) && bus.in_valid;
  assign go        = cond_pass(bus.in_cond, flags_r) && supported(bus.in_opcode);
  assign test_only = opcode_q inside {OP_TST, OP_TEQ, OP_CMP};
  assign arith     = opcode_q inside {OP_ADD, OP_SUB, OP_RSB, OP_CMP};
  assign last_pass = ((state == PASS1) && (opcode_q != OP_BIC)) || (state == PASS2);

  // First-pass operand routing straight from the offered instruction
  always_comb begin
    p1_a   = '0;
    p1_b   = '0;
    p1_ctl = ALU_ADD;
    case (bus.in_opcode)
      OP_AND, OP_TST: begin p1_a = bus.in_op_a; p1_b = bus.in_op_b; p1_ctl = ALU_AND; end
      OP_EOR, OP_TEQ: begin p1_a = bus.in_op_a; p1_b = bus.in_op_b; p1_ctl = ALU_XOR; end
      OP_SUB, OP_CMP: begin p1_a = bus.in_op_a; p1_b = bus.in_op_b; p1_ctl = ALU_SUB; end
      OP_RSB:         begin p1_a = bus.in_op_b; p1_b = bus.in_op_a; p1_ctl = ALU_SUB; end
      OP_ADD:         begin p1_a = bus.in_op_a; p1_b = bus.in_op_b; p1_ctl = ALU_ADD; end
      OP_ORR:         begin p1_a = bus.in_op_a; p1_b = bus.in_op_b; p1_ctl = ALU_OR;  end
      OP_MOV:         begin p1_a = bus.in_op_b; p1_b = bus.in_op_b; p1_ctl = ALU_OR;  end
      OP_BIC, OP_MVN: begin p1_a = bus.in_op_b; p1_ctl = ALU_NOT; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = go ? PASS1 : RESP;
      PASS1:   state_nx = (opcode_q == OP_BIC) ? PASS2 : RESP;
      PASS2:   state_nx = RESP;
      RESP:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q  <= '0;
      s_q       <= 1'b0;
      op_a_q    <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      flags_r   <= '0;
    end else begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= '0;
      if (accept) begin
        opcode_q <= bus.in_opcode;
        s_q      <= bus.in_s;
        op_a_q   <= bus.in_op_a;
        rd_q     <= bus.in_rd;
        if (go) begin
          alu_a_q   <= p1_a;
          alu_b_q   <= p1_b;
          alu_ctl_q <= p1_ctl;
        end else begin
          result_q <= '0;
          wr_q     <= 1'b0;
          err_q    <= !supported(bus.in_opcode);
        end
      end else if ((state == PASS1) && (opcode_q == OP_BIC)) begin
        // BIC second pass: Rn AND the inverted operand captured in pass one
        alu_a_q   <= op_a_q;
        alu_b_q   <= bus.alu_result;
        alu_ctl_q <= ALU_AND;
      end else if (last_pass) begin
        result_q <= bus.alu_result;
        wr_q     <= !test_only;
        err_q    <= 1'b0;
        if (s_q || test_only) begin
          if (arith) flags_r <= bus.alu_flags;
          else       flags_r <= {bus.alu_flags[3:2], flags_r[1:0]};
        end
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == RESP);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_control = alu_ctl_q;
  assign bus.out_result  = result_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_wr      = wr_q;
  assign bus.out_err     = err_q;
  assign bus.flags_q     = flags_r;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with an external ALU model
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(32), .TAG_W(4)) bus();
  alu_op_sequencer #(.WIDTH(32), .TAG_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] result;
    logic [3:0]  rd;
    logic        wr;
    logic        err;
    int          lat;
    logic [3:0]  flags;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mflags;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath ALU the sequencer drives
  logic [32:0] aw;
  logic        ac, av;
  always_comb begin
    aw = '0;
    ac = 1'b0;
    av = 1'b0;
    case (bus.alu_control)
      3'b000: begin
        aw = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        ac = aw[32];
        av = (bus.alu_a[31] == bus.alu_b[31]) && (aw[31] != bus.alu_a[31]);
      end
      3'b001: begin
        aw = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        ac = aw[32];
        av = (bus.alu_a[31] != bus.alu_b[31]) && (aw[31] != bus.alu_a[31]);
      end
      3'b010:  aw = {1'b0, bus.alu_a & bus.alu_b};
      3'b011:  aw = {1'b0, bus.alu_a | bus.alu_b};
      3'b100:  aw = {1'b0, bus.alu_a << bus.alu_b[4:0]};
      3'b101:  aw = {1'b0, bus.alu_a >> bus.alu_b[4:0]};
      3'b110:  aw = {1'b0, bus.alu_a ^ bus.alu_b};
      default: aw = {1'b0, ~bus.alu_a};
    endcase
    bus.alu_result = aw[31:0];
    bus.alu_flags  = {aw[31], aw[31:0] == 32'd0, ac, av};
  end

  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0: return z;               4'h1: return !z;
      4'h2: return cf;              4'h3: return !cf;
      4'h4: return n;               4'h5: return !n;
      4'h6: return v;               4'h7: return !v;
      4'h8: return cf & !z;         4'h9: return !cf | z;
      4'hA: return n == v;          4'hB: return n != v;
      4'hC: return !z & (n == v);   4'hD: return z | (n != v);
      4'hE: return 1'b1;            default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t predict(input logic [3:0] c, input logic [3:0] op, input logic s,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] rd, input logic [3:0] fl);
    exp_t e;
    logic [32:0] w;
    logic [31:0] r;
    logic cc, v, arith, sup, tst;
    sup = !(op == 4'h5 || op == 4'h6 || op == 4'h7 || op == 4'hB);
    tst = (op == 4'h8 || op == 4'h9 || op == 4'hA);
    e.rd = rd; e.flags = fl; e.result = '0; e.wr = 1'b0; e.err = !sup; e.lat = 1;
    if (sup && model_cond(c, fl)) begin
      cc = fl[1]; v = fl[0]; arith = 1'b0; r = '0;
      case (op)
        4'h0, 4'h8: r = a & b;
        4'h1, 4'h9: r = a ^ b;
        4'h2, 4'hA: begin w = a - b; r = w[31:0]; cc = (a >= b);
                          v = (a[31] != b[31]) && (r[31] != a[31]); arith = 1'b1; end
        4'h3:       begin r = b - a; cc = (b >= a);
                          v = (a[31] != b[31]) && (r[31] != b[31]); arith = 1'b1; end
        4'h4:       begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cc = w[32];
                          v = (a[31] == b[31]) && (r[31] != a[31]); arith = 1'b1; end
        4'hC:       r = a | b;
        4'hD:       r = b;
        4'hE:       r = a & ~b;
        default:    r = ~b;
      endcase
      e.result = r;
      e.wr     = !tst;
      e.lat    = (op == 4'hE) ? 3 : 2;
      if (s || tst)
        e.flags = {r[31], r == 32'd0, arith ? cc : fl[1], arith ? v : fl[0]};
    end
    return e;
  endfunction

  task automatic send(input logic [3:0] c, input logic [3:0] op, input logic s,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_in_ready got=%b exp=1", bus.in_ready);
    end
    bus.in_cond = c; bus.in_opcode = op; bus.in_s = s;
    bus.in_op_a = a; bus.in_op_b = b; bus.in_rd = rd; bus.in_valid = 1'b1;
    sb.push_back(predict(c, op, s, a, b, rd, mflags));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic get_resp(input string name, input bit chk_lat);
    exp_t e;
    int lat;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    while (bus.out_valid !== 1'b1 && (cyc - acc_cyc) < 20) @(negedge clk);
    lat = cyc - acc_cyc + 1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid timeout got=%b exp=1", name, bus.out_valid);
      return;
    end
    if (chk_lat) begin
      checks++;
      if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, e.lat); end
    end
    checks++;
    if (bus.out_result !== e.result) begin failures++; $display("FAIL %s result got=%h exp=%h", name, bus.out_result, e.result); end
    checks++;
    if (bus.out_rd !== e.rd) begin failures++; $display("FAIL %s rd got=%h exp=%h", name, bus.out_rd, e.rd); end
    checks++;
    if (bus.out_wr !== e.wr) begin failures++; $display("FAIL %s wr got=%b exp=%b", name, bus.out_wr, e.wr); end
    checks++;
    if (bus.out_err !== e.err) begin failures++; $display("FAIL %s err got=%b exp=%b", name, bus.out_err, e.err); end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s post_handshake valid/ready got=%b%b exp=01", name, bus.out_valid, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.flags_q !== e.flags) begin failures++; $display("FAIL %s flags got=%b exp=%b", name, bus.flags_q, e.flags); end
    mflags = e.flags;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_cond = '0; bus.in_opcode = '0;
    bus.in_s = 1'b0; bus.in_op_a = '0; bus.in_op_b = '0; bus.in_rd = '0;
    mflags = 4'b0000;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.flags_q !== 4'b0000 || bus.out_result !== 32'd0 ||
        bus.alu_control !== 3'b000 || bus.alu_a !== 32'd0 || bus.out_wr !== 1'b0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state valid=%b flags=%b result=%h ctl=%b exp 0/0000/0/000",
               bus.out_valid, bus.flags_q, bus.out_result, bus.alu_control);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_add();
    send(4'hE, 4'h4, 1'b1, 32'd5, 32'd3, 4'd2);
    get_resp("add", 1'b1);
  endtask

  task automatic test_cmp_mov();
    send(4'hE, 4'hA, 1'b0, 32'd7, 32'd7, 4'd4);
    get_resp("cmp", 1'b1);
    send(4'h0, 4'hD, 1'b0, 32'd0, 32'h1234, 4'd3);
    get_resp("mov_eq", 1'b1);
    send(4'h1, 4'hD, 1'b0, 32'd0, 32'h5678, 4'd5);
    get_resp("mov_ne", 1'b1);
  endtask

  task automatic test_bic();
    send(4'hE, 4'hE, 1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 4'd6);
    checks++;
    if (bus.alu_control !== 3'b111 || bus.alu_a !== 32'h0F0F0F0F || bus.alu_b !== 32'd0) begin
      failures++;
      $display("FAIL bic_pass1 ctl=%b a=%h b=%h exp 111/0f0f0f0f/0", bus.alu_control, bus.alu_a, bus.alu_b);
    end
    @(negedge clk);
    checks++;
    if (bus.alu_control !== 3'b010 || bus.alu_a !== 32'hFF00FF00 || bus.alu_b !== 32'hF0F0F0F0) begin
      failures++;
      $display("FAIL bic_pass2 ctl=%b a=%h b=%h exp 010/ff00ff00/f0f0f0f0", bus.alu_control, bus.alu_a, bus.alu_b);
    end
    get_resp("bic", 1'b1);
  endtask

  task automatic test_rsb_unsupported();
    send(4'hE, 4'h3, 1'b0, 32'd3, 32'd10, 4'd7);
    checks++;
    if (bus.alu_a !== 32'd10 || bus.alu_b !== 32'd3 || bus.alu_control !== 3'b001) begin
      failures++;
      $display("FAIL rsb_operands a=%h b=%h ctl=%b exp a/3/001", bus.alu_a, bus.alu_b, bus.alu_control);
    end
    get_resp("rsb", 1'b1);
    send(4'hE, 4'h5, 1'b1, 32'd1, 32'd2, 4'd8);
    get_resp("unsupported", 1'b1);
  endtask

  task automatic test_hold();
    send(4'hE, 4'h4, 1'b0, 32'd100, 32'd23, 4'd9);
    for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) @(negedge clk);
    bus.in_cond = 4'hE; bus.in_opcode = 4'hD; bus.in_op_b = 32'hDEAD; bus.in_rd = 4'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || sb.size() == 0 ||
          bus.out_result !== sb[0].result || bus.out_rd !== sb[0].rd) begin
        failures++;
        $display("FAIL hold_cycle%0d valid=%b ready=%b result=%h rd=%h", i,
                 bus.out_valid, bus.in_ready, bus.out_result, bus.out_rd);
      end
    end
    get_resp("hold", 1'b0);
  endtask

  task automatic test_reset_mid_bic();
    send(4'hE, 4'hE, 1'b1, 32'h12345678, 32'h000000FF, 4'd10);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.flags_q !== 4'b0000 || bus.alu_control !== 3'b000) begin
      failures++;
      $display("FAIL async_reset valid=%b flags=%b ctl=%b exp 0/0000/000", bus.out_valid, bus.flags_q, bus.alu_control);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    mflags = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_reset ready=%b valid=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
    send(4'hE, 4'h2, 1'b1, 32'd3, 32'd5, 4'd1);
    get_resp("sub_after_reset", 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [12];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 15)), ops[i], 1'($urandom_range(0, 1)),
           $urandom, $urandom, 4'($urandom_range(0, 15)));
      get_resp("random", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp_mov();
    test_bic();
    test_rsb_unsupported();
    test_hold();
    test_reset_mid_bic();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
